// File: rtl/siso_pkg.sv
// Shared constants and types for the SISO decoder front end.
package siso_pkg;

   localparam int DEFAULT_W          = 16;
   localparam int DEFAULT_ALPHA_INIT = -128;
   localparam int TAIL_STEPS         = 3;
   localparam int N_STATES           = 8;

   typedef logic signed [DEFAULT_W-1:0] metric_vec_t [N_STATES];

   typedef enum logic {
      PH_SYS    = 1'b0,
      PH_PARITY = 1'b1
   } phase_e;

endpackage

// File: rtl/alpha.sv
// Forward state-metric recursion with normalization to state 0 and per-block step counting.
module alpha
   import siso_pkg::*;
#(
   parameter int W          = DEFAULT_W,
   parameter int ALPHA_INIT = DEFAULT_ALPHA_INIT
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                valid_b,
   input  logic signed [W-1:0] b1,
   input  logic signed [W-1:0] b2,
   input  logic [15:0]         len_i,
   output logic signed [W-1:0] alpha_o [N_STATES],
   output logic                valid_alpha
);

   logic signed [W-1:0] metric_q [N_STATES];
   logic signed [W-1:0] metric_d [N_STATES];
   logic signed [W-1:0] alpha_q  [N_STATES];
   logic signed [W-1:0] alpha_d  [N_STATES];
   logic signed [W-1:0] n        [N_STATES];
   logic signed [W-1:0] norm     [N_STATES];
   logic                valid_q, valid_d;
   logic [16:0]         step_q, step_d;
   logic [15:0]         len_q, len_d;
   logic [15:0]         len_eff;
   logic [16:0]         last_step;

   function automatic logic signed [W-1:0] smax(input logic signed [W-1:0] x,
                                                input logic signed [W-1:0] y);
      return (x > y) ? x : y;
   endfunction

   // The block length travels with every pair; only the value riding with step 0 is kept.
   always_comb begin
      n[0] = smax(metric_q[0] + b1, metric_q[1] - b1);
      n[4] = smax(metric_q[1] + b1, metric_q[0] - b1);
      n[1] = smax(metric_q[3] + b2, metric_q[2] - b2);
      n[5] = smax(metric_q[2] + b2, metric_q[3] - b2);
      n[2] = smax(metric_q[4] + b2, metric_q[5] - b2);
      n[6] = smax(metric_q[5] + b2, metric_q[4] - b2);
      n[3] = smax(metric_q[7] + b1, metric_q[6] - b1);
      n[7] = smax(metric_q[6] + b1, metric_q[7] - b1);
      for (int k = 0; k < N_STATES; k++) begin
         norm[k]     = n[k] - n[0];
         metric_d[k] = metric_q[k];
         alpha_d[k]  = alpha_q[k];
      end
      valid_d   = 1'b0;
      step_d    = step_q;
      len_d     = len_q;
      len_eff   = (step_q == '0) ? len_i : len_q;
      last_step = 17'(len_eff) + 17'(TAIL_STEPS - 1);
      if (valid_b) begin
         valid_d = 1'b1;
         if (step_q == '0) begin
            len_d = len_i;
         end
         for (int k = 0; k < N_STATES; k++) begin
            alpha_d[k] = norm[k];
         end
         if (step_q == last_step) begin
            step_d      = '0;
            metric_d[0] = '0;
            for (int k = 1; k < N_STATES; k++) begin
               metric_d[k] = W'(ALPHA_INIT);
            end
         end else begin
            step_d = step_q + 17'd1;
            for (int k = 0; k < N_STATES; k++) begin
               metric_d[k] = norm[k];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         metric_q[0] <= '0;
         for (int k = 1; k < N_STATES; k++) begin
            metric_q[k] <= W'(ALPHA_INIT);
         end
         for (int k = 0; k < N_STATES; k++) begin
            alpha_q[k] <= '0;
         end
         valid_q <= 1'b0;
         step_q  <= '0;
         len_q   <= '0;
      end else begin
         for (int k = 0; k < N_STATES; k++) begin
            metric_q[k] <= metric_d[k];
            alpha_q[k]  <= alpha_d[k];
         end
         valid_q <= valid_d;
         step_q  <= step_d;
         len_q   <= len_d;
      end
   end

   assign alpha_o     = alpha_q;
   assign valid_alpha = valid_q;

endmodule

// File: rtl/init_branch.sv
// Branch metric stage: b1 = sys+apriori+parity, b2 = sys+apriori-parity (W-bit wrap).
module init_branch
   import siso_pkg::*;
#(
   parameter int W = DEFAULT_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                valid_sp,
   input  logic signed [W-1:0] sys_i,
   input  logic signed [W-1:0] par_i,
   input  logic signed [W-1:0] apr_i,
   input  logic [15:0]         len_i,
   output logic signed [W-1:0] b1_o,
   output logic signed [W-1:0] b2_o,
   output logic [15:0]         len_o,
   output logic                valid_out
);

   logic signed [W-1:0] b1_q, b1_d;
   logic signed [W-1:0] b2_q, b2_d;
   logic [15:0]         len_q, len_d;
   logic                valid_q, valid_d;

   always_comb begin
      b1_d    = b1_q;
      b2_d    = b2_q;
      len_d   = len_q;
      valid_d = 1'b0;
      if (valid_sp) begin
         b1_d    = sys_i + apr_i + par_i;
         b2_d    = sys_i + apr_i - par_i;
         len_d   = len_i;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         b1_q    <= '0;
         b2_q    <= '0;
         len_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         b1_q    <= b1_d;
         b2_q    <= b2_d;
         len_q   <= len_d;
         valid_q <= valid_d;
      end
   end

   assign b1_o      = b1_q;
   assign b2_o      = b2_q;
   assign len_o     = len_q;
   assign valid_out = valid_q;

endmodule

// File: rtl/sys_parity.sv
// Splits the interleaved soft-bit stream into registered sys/parity/apriori triples.
module sys_parity
   import siso_pkg::*;
#(
   parameter int W = DEFAULT_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic signed [W-1:0] in,
   input  logic                valid_in,
   input  logic signed [W-1:0] apriori,
   input  logic                valid_apriori,
   input  logic [15:0]         blklen,
   output logic signed [W-1:0] sys_o,
   output logic signed [W-1:0] par_o,
   output logic signed [W-1:0] apr_o,
   output logic [15:0]         len_o,
   output logic                valid_sp
);

   phase_e              phase_q, phase_d;
   logic signed [W-1:0] sys_buf_q, sys_buf_d;
   logic [15:0]         len_buf_q, len_buf_d;
   logic signed [W-1:0] sys_q, sys_d;
   logic signed [W-1:0] par_q, par_d;
   logic signed [W-1:0] apr_q, apr_d;
   logic [15:0]         len_q, len_d;
   logic                valid_sp_q, valid_sp_d;

   // Phase always lands back on PH_SYS after a parity sample, so pair boundaries
   // coincide with block boundaries without any feedback from the step counter.
   always_comb begin
      phase_d    = phase_q;
      sys_buf_d  = sys_buf_q;
      len_buf_d  = len_buf_q;
      sys_d      = sys_q;
      par_d      = par_q;
      apr_d      = apr_q;
      len_d      = len_q;
      valid_sp_d = 1'b0;
      if (valid_in) begin
         if (phase_q == PH_SYS) begin
            sys_buf_d = in;
            len_buf_d = blklen;
            phase_d   = PH_PARITY;
         end else begin
            sys_d      = sys_buf_q;
            par_d      = in;
            apr_d      = valid_apriori ? apriori : '0;
            len_d      = len_buf_q;
            valid_sp_d = 1'b1;
            phase_d    = PH_SYS;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         phase_q    <= PH_SYS;
         sys_buf_q  <= '0;
         len_buf_q  <= '0;
         sys_q      <= '0;
         par_q      <= '0;
         apr_q      <= '0;
         len_q      <= '0;
         valid_sp_q <= 1'b0;
      end else begin
         phase_q    <= phase_d;
         sys_buf_q  <= sys_buf_d;
         len_buf_q  <= len_buf_d;
         sys_q      <= sys_d;
         par_q      <= par_d;
         apr_q      <= apr_d;
         len_q      <= len_d;
         valid_sp_q <= valid_sp_d;
      end
   end

   assign sys_o    = sys_q;
   assign par_o    = par_q;
   assign apr_o    = apr_q;
   assign len_o    = len_q;
   assign valid_sp = valid_sp_q;

endmodule

// File: rtl/siso_front_end.sv
// SISO front end: stream splitter -> branch metrics -> normalized forward recursion.
module siso_front_end
   import siso_pkg::*;
#(
   parameter int W          = DEFAULT_W,
   parameter int ALPHA_INIT = DEFAULT_ALPHA_INIT
) (
   input  logic                clk,
   input  logic                rst,
   input  logic signed [W-1:0] in,
   input  logic                valid_in,
   input  logic signed [W-1:0] apriori,
   input  logic                valid_apriori,
   input  logic [15:0]         blklen,
   output logic signed [W-1:0] init_branch1_t,
   output logic signed [W-1:0] init_branch2_t,
   output logic                valid_out,
   output logic signed [W-1:0] alpha_0,
   output logic signed [W-1:0] alpha_1,
   output logic signed [W-1:0] alpha_2,
   output logic signed [W-1:0] alpha_3,
   output logic signed [W-1:0] alpha_4,
   output logic signed [W-1:0] alpha_5,
   output logic signed [W-1:0] alpha_6,
   output logic signed [W-1:0] alpha_7,
   output logic                valid_alpha
);

   logic signed [W-1:0] sp_sys, sp_par, sp_apr;
   logic [15:0]         sp_len, br_len;
   logic                valid_sp;
   logic signed [W-1:0] alpha_vec [N_STATES];

   sys_parity #(.W(W)) u_sys_parity (
      .clk           (clk),
      .rst           (rst),
      .in            (in),
      .valid_in      (valid_in),
      .apriori       (apriori),
      .valid_apriori (valid_apriori),
      .blklen        (blklen),
      .sys_o         (sp_sys),
      .par_o         (sp_par),
      .apr_o         (sp_apr),
      .len_o         (sp_len),
      .valid_sp      (valid_sp)
   );

   init_branch #(.W(W)) u_init_branch (
      .clk       (clk),
      .rst       (rst),
      .valid_sp  (valid_sp),
      .sys_i     (sp_sys),
      .par_i     (sp_par),
      .apr_i     (sp_apr),
      .len_i     (sp_len),
      .b1_o      (init_branch1_t),
      .b2_o      (init_branch2_t),
      .len_o     (br_len),
      .valid_out (valid_out)
   );

   alpha #(.W(W), .ALPHA_INIT(ALPHA_INIT)) u_alpha (
      .clk         (clk),
      .rst         (rst),
      .valid_b     (valid_out),
      .b1          (init_branch1_t),
      .b2          (init_branch2_t),
      .len_i       (br_len),
      .alpha_o     (alpha_vec),
      .valid_alpha (valid_alpha)
   );

   assign alpha_0 = alpha_vec[0];
   assign alpha_1 = alpha_vec[1];
   assign alpha_2 = alpha_vec[2];
   assign alpha_3 = alpha_vec[3];
   assign alpha_4 = alpha_vec[4];
   assign alpha_5 = alpha_vec[5];
   assign alpha_6 = alpha_vec[6];
   assign alpha_7 = alpha_vec[7];

endmodule

// File: tb/tb_siso_front_end.sv
// Bench for siso_front_end: pair-level reference model with timed scoreboards, vector table, corner sequences.
module tb_siso_front_end;
   import siso_pkg::*;

   localparam int W = 16;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic signed [W-1:0] in_s = '0;
   logic                valid_in = 1'b0;
   logic signed [W-1:0] apriori = '0;
   logic                valid_apriori = 1'b0;
   logic [15:0]         blklen = 16'd100;
   logic signed [W-1:0] b1_w, b2_w;
   logic                valid_out;
   logic signed [W-1:0] alpha_w [8];
   logic                valid_alpha;

   siso_front_end #(.W(W), .ALPHA_INIT(-128)) dut (
      .clk            (clk),
      .rst            (rst),
      .in             (in_s),
      .valid_in       (valid_in),
      .apriori        (apriori),
      .valid_apriori  (valid_apriori),
      .blklen         (blklen),
      .init_branch1_t (b1_w),
      .init_branch2_t (b2_w),
      .valid_out      (valid_out),
      .alpha_0        (alpha_w[0]),
      .alpha_1        (alpha_w[1]),
      .alpha_2        (alpha_w[2]),
      .alpha_3        (alpha_w[3]),
      .alpha_4        (alpha_w[4]),
      .alpha_5        (alpha_w[5]),
      .alpha_6        (alpha_w[6]),
      .alpha_7        (alpha_w[7]),
      .valid_alpha    (valid_alpha)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int          due;
      int          b1;
      int          b2;
   } bexp_t;

   typedef struct {
      int               due;
      logic [7:0][15:0] v;
   } aexp_t;

   typedef struct {
      int sys;
      int par;
      int apr;
      bit va;
      int exp_b1;
      int exp_b2;
   } vec_t;

   bexp_t bq[$];
   aexp_t aq[$];

   // Reference model state: trellis metrics as plain integers, one step per pair.
   int  m [8];
   int  pair_idx;
   int  blk_model;
   bit  phase_sys;
   int  sys_hold;
   int  last_b1, last_b2;
   int  last_alpha [8];
   int  a_pulses;
   bit  mon_en = 1'b0;

   int  src_plus  [8] = '{0, 3, 4, 7, 1, 2, 5, 6};
   int  src_minus [8] = '{1, 2, 5, 6, 0, 3, 4, 7};
   bit  uses_b2   [8] = '{0, 1, 1, 0, 0, 1, 1, 0};

   metric_vec_t init_step_alpha = '{16'sd0, -16'sd136, -16'sd136, -16'sd128,
                                    -16'sd32, -16'sd136, -16'sd136, -16'sd128};

   function automatic int wrap(input int v);
      logic signed [15:0] t;
      t = v[15:0];
      return int'(t);
   endfunction

   task automatic checkOutput(input string name, input int actual, input int expected);
      total++;
      if (actual != expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   task automatic modelReset();
      m[0] = 0;
      for (int k = 1; k < 8; k++) m[k] = -128;
      pair_idx  = 0;
      blk_model = 0;
      phase_sys = 1'b1;
      sys_hold  = 0;
      last_b1   = 0;
      last_b2   = 0;
      for (int k = 0; k < 8; k++) last_alpha[k] = 0;
      a_pulses  = 0;
      bq.delete();
      aq.delete();
   endtask

   task automatic modelPair(input int s, input int p, input int a);
      bexp_t be;
      aexp_t ae;
      int    b1, b2, bb, x, y;
      int    nv [8];
      b1 = wrap(s + a + p);
      b2 = wrap(s + a - p);
      be.due = cyc + 2;
      be.b1  = b1;
      be.b2  = b2;
      bq.push_back(be);
      for (int k = 0; k < 8; k++) begin
         bb    = uses_b2[k] ? b2 : b1;
         x     = wrap(m[src_plus[k]] + bb);
         y     = wrap(m[src_minus[k]] - bb);
         nv[k] = (x > y) ? x : y;
      end
      ae.due = cyc + 3;
      for (int k = 0; k < 8; k++) ae.v[k] = 16'(wrap(nv[k] - nv[0]));
      aq.push_back(ae);
      pair_idx++;
      if (pair_idx == blk_model + 3) begin
         m[0] = 0;
         for (int k = 1; k < 8; k++) m[k] = -128;
         pair_idx = 0;
      end else begin
         for (int k = 0; k < 8; k++) m[k] = wrap(nv[k] - nv[0]);
      end
   endtask

   task automatic doReset();
      @(negedge clk);
      rst           = 1'b1;
      valid_in      = 1'b0;
      valid_apriori = 1'b0;
      modelReset();
      @(negedge clk);
      rst = 1'b0;
      checkOutput("rst_valid_out", int'(valid_out), 0);
      checkOutput("rst_valid_alpha", int'(valid_alpha), 0);
      checkOutput("rst_b1", int'(b1_w), 0);
      checkOutput("rst_b2", int'(b2_w), 0);
      for (int k = 0; k < 8; k++) checkOutput($sformatf("rst_alpha_%0d", k), int'(alpha_w[k]), 0);
   endtask

   task automatic sendSample(input int val, input int apr, input bit va);
      @(negedge clk);
      in_s          = 16'(val);
      apriori       = 16'(apr);
      valid_apriori = va;
      valid_in      = 1'b1;
      if (phase_sys) begin
         sys_hold = wrap(val);
         if (pair_idx == 0) blk_model = int'(blklen);
         phase_sys = 1'b0;
      end else begin
         modelPair(sys_hold, wrap(val), va ? wrap(apr) : 0);
         phase_sys = 1'b1;
      end
   endtask

   task automatic idleCycle();
      @(negedge clk);
      valid_in      = 1'b0;
      in_s          = 16'($urandom);
      apriori       = 16'($urandom);
      valid_apriori = 1'($urandom_range(0, 1));
   endtask

   task automatic applyStimulus(input int s, input int p, input int a, input bit va, input int gap);
      sendSample(s, $urandom, 1'($urandom_range(0, 1)));
      repeat (gap) idleCycle();
      sendSample(p, a, va);
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && (bq.size() != 0 || aq.size() != 0); i++) idleCycle();
      checkOutput("drain_pending", bq.size() + aq.size(), 0);
      idleCycle();
   endtask

   task automatic checkInitAlpha(input string tag);
      for (int k = 0; k < 8; k++)
         checkOutput($sformatf("%s_alpha_%0d", tag, k), int'(alpha_w[k]), int'(init_step_alpha[k]));
   endtask

   // Timed scoreboard: each expected pulse must appear on its exact cycle; outputs hold otherwise.
   always begin
      @(posedge clk);
      #2;
      if (mon_en) begin
         if (valid_out) begin
            if (bq.size() == 0 || bq[0].due != cyc) begin
               checkOutput("valid_out_timing", 1, 0);
            end else begin
               bexp_t e;
               e = bq.pop_front();
               checkOutput("b1", int'(b1_w), e.b1);
               checkOutput("b2", int'(b2_w), e.b2);
               last_b1 = e.b1;
               last_b2 = e.b2;
            end
         end else begin
            if (bq.size() != 0 && bq[0].due <= cyc) begin
               checkOutput("valid_out_missing", 0, 1);
               void'(bq.pop_front());
            end
            checkOutput("b1_hold", int'(b1_w), last_b1);
            checkOutput("b2_hold", int'(b2_w), last_b2);
         end
         if (valid_alpha) begin
            a_pulses++;
            if (aq.size() == 0 || aq[0].due != cyc) begin
               checkOutput("valid_alpha_timing", 1, 0);
            end else begin
               aexp_t e;
               e = aq.pop_front();
               for (int k = 0; k < 8; k++) begin
                  checkOutput($sformatf("alpha_%0d", k), int'(alpha_w[k]), int'($signed(e.v[k])));
                  last_alpha[k] = int'($signed(e.v[k]));
               end
            end
         end else begin
            if (aq.size() != 0 && aq[0].due <= cyc) begin
               checkOutput("valid_alpha_missing", 0, 1);
               void'(aq.pop_front());
            end
            for (int k = 0; k < 8; k++)
               checkOutput($sformatf("alpha_%0d_hold", k), int'(alpha_w[k]), last_alpha[k]);
         end
      end
   end

   vec_t vecs [6];

   initial begin
      vecs[0] = '{sys: 10,     par: 4,  apr: 2,  va: 1'b1, exp_b1: 16,     exp_b2: 8};
      vecs[1] = '{sys: 5,      par: 3,  apr: 7,  va: 1'b0, exp_b1: 8,      exp_b2: 2};
      vecs[2] = '{sys: 7,      par: 1,  apr: 0,  va: 1'b1, exp_b1: 8,      exp_b2: 6};
      vecs[3] = '{sys: 32767,  par: 1,  apr: 0,  va: 1'b1, exp_b1: -32768, exp_b2: 32766};
      vecs[4] = '{sys: -32768, par: 1,  apr: -1, va: 1'b1, exp_b1: -32768, exp_b2: 32766};
      vecs[5] = '{sys: -3,     par: -5, apr: 0,  va: 1'b1, exp_b1: -8,     exp_b2: 2};

      doReset();
      mon_en = 1'b1;

      // Table: each vector is a fresh first step of a block.
      blklen = 16'd100;
      for (int i = 0; i < 6; i++) begin
         doReset();
         applyStimulus(vecs[i].sys, vecs[i].par, vecs[i].apr, vecs[i].va, 0);
         drain();
         checkOutput($sformatf("tbl%0d_b1", i), int'(b1_w), vecs[i].exp_b1);
         checkOutput($sformatf("tbl%0d_b2", i), int'(b2_w), vecs[i].exp_b2);
         if (i == 0) checkInitAlpha("tbl0");
      end

      // Block of K=4 -> 7 steps; the 8th pair restarts from block-start metrics.
      doReset();
      blklen = 16'd4;
      applyStimulus(10, 4, 2, 1'b1, 0);
      blklen = 16'd9;
      for (int i = 0; i < 6; i++)
         applyStimulus($urandom_range(0, 200) - 100, $urandom_range(0, 200) - 100,
                       $urandom_range(0, 60) - 30, 1'($urandom_range(0, 1)), 0);
      drain();
      checkOutput("blk_pulses", a_pulses, 7);
      blklen = 16'd4;
      applyStimulus(10, 4, 2, 1'b1, 0);
      drain();
      checkOutput("blk_pulses_8", a_pulses, 8);
      checkInitAlpha("blk8");

      // Reset after a lone sys sample discards it.
      doReset();
      blklen = 16'd100;
      sendSample(9, 0, 1'b0);
      idleCycle();
      doReset();
      applyStimulus(7, 1, 0, 1'b0, 0);
      drain();
      checkOutput("rstmid_b1", int'(b1_w), 8);
      checkOutput("rstmid_b2", int'(b2_w), 6);

      // Idle cycles between sys and parity must not change the result.
      doReset();
      applyStimulus(10, 4, 2, 1'b1, 3);
      drain();
      checkOutput("gap_b1", int'(b1_w), 16);
      checkOutput("gap_b2", int'(b2_w), 8);
      checkInitAlpha("gap");

      // Randomized streaming with short blocks, gaps and mid-block blklen changes.
      doReset();
      for (int i = 0; i < 60; i++) begin
         blklen = 16'($urandom_range(0, 5));
         applyStimulus(int'($urandom), int'($urandom), int'($urandom),
                       1'($urandom_range(0, 1)), $urandom_range(0, 2));
         repeat ($urandom_range(0, 2)) idleCycle();
      end
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/siso_front_end.md
SISO_FRONT_END -- requirements
Module: siso_front_end

Interface
REQ-001 Parameter W, default 16, sample and metric width in bits.
REQ-002 Parameter ALPHA_INIT, default -128, initial metric of states 1..7.
REQ-003 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 in  in  W  signed soft-bit stream: sys, parity, sys, parity...
REQ-007 valid_in  in  1  in is valid this cycle.
REQ-008 apriori  in  W  signed a-priori LLR for the current pair.
REQ-009 valid_apriori  in  1  apriori is valid this cycle.
REQ-010 blklen  in  16  info block length K; trellis steps per block = K+3.
REQ-011 init_branch1_t  out  W  branch metric b1.
REQ-012 init_branch2_t  out  W  branch metric b2.
REQ-013 valid_out  out  1  b1/b2 valid.
REQ-014 alpha_0..alpha_7  out  W each  normalized forward state metrics.
REQ-015 valid_alpha  out  1  alpha_0..7 valid.

Function
REQ-016 Splitter: the first valid_in sample after reset or block end is sys, the next is parity, alternating; invalid cycles hold the phase.
REQ-017 sys/parity pair is registered and valid_sp pulses 1 cycle after the parity sample (T+1).
REQ-018 apriori is sampled on the parity-sample cycle T; if valid_apriori is low then, apriori = 0.
REQ-019 Branch stage at T+2: b1 = sys+apriori+parity, b2 = sys+apriori-parity, W-bit two's-complement wrap; valid_out pulses for 1 cycle.
REQ-020 Alpha stage at T+3 updates from previous metrics a0..a7 (signed compares, strict >, tie takes second operand):
 n0=max(a0+b1, a1-b1); n4=max(a1+b1, a0-b1);
 n1=max(a3+b2, a2-b2); n5=max(a2+b2, a3-b2);
 n2=max(a4+b2, a5-b2); n6=max(a5+b2, a4-b2);
 n3=max(a7+b1, a6-b1); n7=max(a6+b1, a7-b1).
REQ-021 Normalization: stored/output alpha_k = n_k - n0 (alpha_0 always 0); W-bit wrap; valid_alpha pulses 1 cycle.
REQ-022 Block start metrics: a0=0, a1..a7=ALPHA_INIT.
REQ-023 A step counter counts valid_out pulses; after the (blklen+3)th step, alpha metrics and splitter phase return to block-start values for the next block.
REQ-024 Pipeline is fully streaming, one pair per 2 valid_in cycles; no backpressure; gaps in valid_in allowed anywhere.
REQ-025 blklen is sampled at the first sys sample of each block; changes mid-block are ignored.
REQ-026 Outputs hold last values when their valid is low.

Reset
REQ-027 rst clears phase and step counter, sets metrics to block-start values, drives all valids low and init_branch1_t/init_branch2_t to 0, alpha_0..7 outputs to 0.
REQ-028 rst mid-block discards any partial pair and in-flight pipeline data; the next valid_in sample is sys.

Structure
REQ-029 Shared package siso_pkg holds W, ALPHA_INIT, the tail-step constant 3, and a metric-vector typedef (8 x W signed).
REQ-030 Three sub-modules, instantiated in order: sys_parity (splitter), init_branch (branch metrics), alpha (forward recursion + normalization + step counter).

Verification
REQ-031 Reset then in=10,4 with apriori=2/valid_apriori=1 on the 4 -> valid_out at T+2 with b1=16, b2=8.
REQ-032 Same step from init -> valid_alpha at T+3 with alpha = 0,-136,-136,-128,-32,-136,-136,-128.
REQ-033 valid_apriori=0 on parity cycle with sys=5, parity=3 -> b1=8, b2=2.
REQ-034 blklen=4: 7 pairs -> 7 valid_alpha pulses; the 8th pair's alpha is computed from block-start metrics.
REQ-035 Assert rst after a sys sample, then feed 7,1 -> sys=7, parity=1 is the pair used (b1=8, b2=6 with apriori 0).
REQ-036 Gapped valid_in (idle cycles between sys and parity) -> identical b1/b2/alpha to gapless run.
